// File: rtl/ysyx_24090012_lsu_resp.sv
// ysyx_24090012_lsu_resp: LSU responder for the EXU memory handshake.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
module ysyx_24090012_lsu_resp #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] exu_to_lsu_inst,
    output logic        mem_ready,
    output logic [31:0] lsu_rdata,
    output logic [31:0] lsu_inst,
    output logic        lsu_err,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] inst_q;
    logic [31:0] rdata_q;
    logic        ld_q;
    logic        st_q;
    logic        err_q;
    logic [15:0] tcnt;

    logic [6:0]  in_op;
    logic [2:0]  in_f3;
    logic        in_ld;
    logic        in_st;
    logic        in_bad;

    assign in_op = exu_to_lsu_inst[6:0];
    assign in_f3 = exu_to_lsu_inst[14:12];

    always_comb begin
        in_ld = 1'b0;
        in_st = 1'b0;
        if (in_op == OP_LOAD) begin
            in_ld = (in_f3 == 3'b000) || (in_f3 == 3'b001) ||
                    (in_f3 == 3'b010) || (in_f3 == 3'b100) ||
                    (in_f3 == 3'b101);
        end
        if (in_op == OP_STORE) begin
            in_st = (in_f3 <= 3'b010);
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        in_bad = 1'b0;
        if (in_ld || in_st) begin
            unique case (in_f3[1:0])
                2'b01:   in_bad = mem_addr[0];
                2'b10:   in_bad = |mem_addr[1:0];
                default: in_bad = 1'b0;
            endcase
        end
    end
`else
    assign in_bad = 1'b0;
`endif

    logic [1:0]  off;
    logic [2:0]  f3_q;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] ld_sh;
    logic [31:0] ld_ext;

    assign off  = addr_q[1:0];
    assign f3_q = inst_q[14:12];

    // Lane-replicate store data; a 4-bit mask drops bytes past the word.
    always_comb begin
        st_mask = 4'b1111;
        st_data = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                st_mask = 4'b0001 << off;
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << off;
                st_data = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_sh = dmem_rdata >> {off, 3'b000};

    always_comb begin
        ld_ext = ld_sh;
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_ext = {24'd0, ld_sh[7:0]};
            3'b101:  ld_ext = {16'd0, ld_sh[15:0]};
            default: ;
        endcase
    end

    logic to_hit;
    assign to_hit = (tcnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            inst_q  <= 32'd0;
            rdata_q <= 32'd0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            err_q   <= 1'b0;
            tcnt    <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_valid) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        inst_q  <= exu_to_lsu_inst;
                        ld_q    <= in_ld;
                        st_q    <= in_st;
                        tcnt    <= 16'd0;
                        err_q   <= in_bad;
                        if ((in_ld || in_st) && !in_bad) begin
                            state <= REQ;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    tcnt <= tcnt + 16'd1;
                    if (to_hit) begin
                        state <= DONE;
                        err_q <= 1'b1;
                    end else if (dmem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    tcnt <= tcnt + 16'd1;
                    if (to_hit) begin
                        state <= DONE;
                        err_q <= 1'b1;
                    end else if (dmem_rvalid) begin
                        state <= DONE;
                        err_q <= dmem_err;
                        if (ld_q) begin
                            rdata_q <= ld_ext;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    logic in_req;
    assign in_req = (state == REQ);

    assign mem_ready  = (state == DONE);
    assign lsu_err    = err_q;
    assign lsu_rdata  = rdata_q;
    assign lsu_inst   = inst_q;
    assign dmem_valid = in_req;
    assign dmem_we    = in_req && st_q;
    assign dmem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = dmem_we ? st_data : 32'd0;
    assign dmem_wmask = dmem_we ? st_mask : 4'd0;

endmodule

// File: tb/tb_ysyx_24090012_lsu_resp.sv
// tb_ysyx_24090012_lsu_resp: directed and random checks of the LSU responder
// against an address/width-rule model and a small bus responder.
module tb_ysyx_24090012_lsu_resp;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] exu_to_lsu_inst;
    logic        mem_ready;
    logic [31:0] lsu_rdata;
    logic [31:0] lsu_inst;
    logic        lsu_err;
    logic        dmem_valid;
    logic        dmem_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    int ntests = 0;
    int nfail  = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    ysyx_24090012_lsu_resp #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .exu_to_lsu_inst (exu_to_lsu_inst),
        .mem_ready       (mem_ready),
        .lsu_rdata       (lsu_rdata),
        .lsu_inst        (lsu_inst),
        .lsu_err         (lsu_err),
        .dmem_valid      (dmem_valid),
        .dmem_ready      (dmem_ready),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wmask      (dmem_wmask),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata),
        .dmem_err        (dmem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_err    = 1'b0;
        dmem_rdata  = $urandom;
    endtask

    // One EXU transaction. a = REQ cycles before dmem_ready, b = WAIT
    // cycles before dmem_rvalid. noise drives stray rvalid while in REQ.
    task automatic run_op(input string tag, input logic [31:0] inst,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int a, input int b, input logic [31:0] rd,
                          input logic er, input logic noise);
        int op, f3, nb, o, n, ek, evc, k, rdy_k, vcnt, wcnt, phase;
        logic is_ld, is_st, mis, tmo, eerr, got_err, unstable;
        logic [3:0]  emask;
        logic [31:0] ewd, v;
        logic [68:0] rec;

        op = int'(inst % 128);
        f3 = int'((inst >> 12) % 8);
        is_ld = (op == 3) && (f3 inside {0, 1, 2, 4, 5});
        is_st = (op == 35) && (f3 <= 2);
        nb = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        o  = int'(addr % 4);
`ifdef LSU_MISALIGN_CHECK_EN
        mis = (is_ld || is_st) && (o % nb != 0);
`else
        mis = 1'b0;
`endif
        tmo = 1'b0;
        evc = 0;
        ek  = 1;
        eerr = mis;
        if ((is_ld || is_st) && !mis) begin
            n = a + b + 2;
            if (n < TO) begin
                ek = n + 1;
                eerr = er;
            end else begin
                ek = TO + 1;
                eerr = 1'b1;
                tmo = 1'b1;
            end
            evc = (a + 1 < TO) ? a + 1 : TO;
        end
        emask = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (nb == 4 || (i >= o && i < o + nb)) emask = emask | 4'(1 << i);
        end
        ewd = (nb == 1) ? (wd % 256) * 32'h01010101 :
              (nb == 2) ? (wd % 65536) * 32'h00010001 : wd;
        if (is_ld && !mis && !tmo) begin
            v = rd >> (8 * o);
            if (nb == 1) begin
                v = v % 256;
                if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
            end else if (nb == 2) begin
                v = v % 65536;
                if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
            end
            exp_rdata = v;
        end

        mem_valid = 1'b1;
        mem_addr = addr;
        mem_wdata = wd;
        exu_to_lsu_inst = inst;
        k = 0; rdy_k = 0; vcnt = 0; wcnt = 0; phase = 0;
        got_err = 1'b0; unstable = 1'b0; rec = '0;
        while (k < 40 && rdy_k == 0) begin
            tick();
            k++;
            if (mem_ready) begin
                rdy_k = k;
                got_err = lsu_err;
            end
            if (dmem_valid) begin
                vcnt++;
                if (vcnt == 1)
                    rec = {dmem_addr, dmem_we, dmem_wmask, dmem_wdata};
                else if (rec !== {dmem_addr, dmem_we, dmem_wmask, dmem_wdata})
                    unstable = 1'b1;
            end
            bus_idle();
            if (rdy_k == 0) begin
                if (phase == 0 && dmem_valid) begin
                    if (vcnt == a + 1) begin
                        dmem_ready = 1'b1;
                        phase = 1;
                    end else if (noise) begin
                        dmem_rvalid = 1'b1;
                        dmem_err = 1'b1;
                    end
                end else if (phase == 1) begin
                    wcnt++;
                    if (wcnt == b + 1) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata = rd;
                        dmem_err = er;
                    end
                end
            end
        end
        tick();
        mem_valid = 1'b0;
        chk({tag, ".ready_once"}, 32'(mem_ready), 32'd0);
        chk({tag, ".ready_cycle"}, 32'(rdy_k), 32'(ek));
        chk({tag, ".err"}, 32'(got_err), 32'(eerr));
        chk({tag, ".valid_cycles"}, 32'(vcnt), 32'(evc));
        chk({tag, ".inst"}, lsu_inst, inst);
        if (evc > 0) begin
            chk({tag, ".addr"}, rec[68:37], addr - 32'(o));
            chk({tag, ".we"}, 32'(rec[36]), 32'(is_st));
            chk({tag, ".stable"}, 32'(unstable), 32'd0);
            if (is_st) begin
                chk({tag, ".wmask"}, 32'(rec[35:32]), 32'(emask));
                chk({tag, ".wdata"}, rec[31:0], ewd);
            end
        end
        if (is_ld && !mis && !tmo && !er)
            chk({tag, ".rdata"}, lsu_rdata, exp_rdata);
    endtask

    initial begin
        int kind, f3, a, b;
        int ld_f3[5] = '{0, 1, 2, 4, 5};
        int bad_f3[3] = '{3, 6, 7};
        logic [31:0] inst, addr;

        rst_n = 1'b0;
        mem_valid = 1'b0;
        mem_addr = 32'd0;
        mem_wdata = 32'd0;
        exu_to_lsu_inst = 32'd0;
        bus_idle();
        tick();
        tick();
        chk("rst.ctrl", 32'({mem_ready, lsu_err, dmem_valid, dmem_we,
                             dmem_wmask}), 32'd0);
        chk("rst.rdata", lsu_rdata, 32'd0);
        chk("rst.inst", lsu_inst, 32'd0);
        chk("rst.daddr", dmem_addr, 32'd0);
        chk("rst.dwdata", dmem_wdata, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst.ready", 32'(mem_ready), 32'd0);

        run_op("nonmem", 32'h00500093, 32'h1234_5678, 32'h0, 0, 0,
               32'h0, 1'b0, 1'b0);
        run_op("sb_o3", 32'h00000023, 32'h8000_0003, 32'h0000_00AB, 0, 0,
               32'h0, 1'b0, 1'b0);
        run_op("lb", 32'h00000003, 32'h8000_0002, 32'h0, 0, 0,
               32'h12F4_5678, 1'b0, 1'b0);
        run_op("lbu", 32'h00004003, 32'h8000_0002, 32'h0, 0, 0,
               32'h12F4_5678, 1'b0, 1'b0);
        run_op("lhu", 32'h00005003, 32'h8000_0002, 32'h0, 0, 0,
               32'h12F4_5678, 1'b0, 1'b0);
        run_op("lw_slow_err", 32'h00002003, 32'h8000_0010, 32'h0, 3, 2,
               32'hDEAD_BEEF, 1'b1, 1'b1);
        run_op("sh_o3", 32'h00001023, 32'h8000_0003, 32'h1234_CDEF, 0, 0,
               32'h0, 1'b0, 1'b0);

        run_op("lb_pre", 32'h00000003, 32'h8000_0001, 32'h0, 1, 1,
               32'h0000_8100, 1'b0, 1'b0);
        run_op("timeout", 32'h00002003, 32'h8000_0020, 32'h0, 50, 0,
               32'h5555_5555, 1'b0, 1'b0);
        chk("timeout.rdata_kept", lsu_rdata, exp_rdata);
        dmem_rvalid = 1'b1;
        dmem_err = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        tick();
        bus_idle();
        chk("late_rvalid.ready", 32'(mem_ready), 32'd0);
        tick();
        chk("late_rvalid.ready2", 32'(mem_ready), 32'd0);
        run_op("after_to", 32'h00A00513, 32'h0, 32'h0, 0, 0,
               32'h0, 1'b0, 1'b0);

        mem_valid = 1'b1;
        exu_to_lsu_inst = 32'h00002083;
        mem_addr = 32'h8000_0040;
        tick();
        chk("rstw.req", 32'(dmem_valid), 32'd1);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chk("rstw.wait", 32'(dmem_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw.ctrl", 32'({mem_ready, lsu_err, dmem_valid, dmem_we,
                              dmem_wmask}), 32'd0);
        chk("rstw.rdata", lsu_rdata, 32'd0);
        chk("rstw.inst", lsu_inst, 32'd0);
        chk("rstw.daddr", dmem_addr, 32'd0);
        mem_valid = 1'b0;
        exp_rdata = 32'd0;
        dmem_rvalid = 1'b1;
        dmem_err = 1'b1;
        dmem_rdata = 32'hA5A5_A5A5;
        tick();
        rst_n = 1'b1;
        tick();
        bus_idle();
        chk("rstw.drop_ready", 32'(mem_ready), 32'd0);
        chk("rstw.drop_rdata", lsu_rdata, 32'd0);
        tick();
        chk("rstw.idle", 32'({mem_ready, dmem_valid}), 32'd0);

`ifdef LSU_MISALIGN_CHECK_EN
        run_op("lw_mis", 32'h00002003, 32'h8000_0002, 32'h0, 0, 0,
               32'h0, 1'b0, 1'b0);
        run_op("lh_mis", 32'h00001003, 32'h8000_0001, 32'h0, 0, 0,
               32'h0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 10);
            inst = $urandom & 32'hFFFF_8F80;
            if (kind == 0) begin
                inst = inst | 32'h13;
            end else if (kind <= 5) begin
                f3 = ld_f3[kind - 1];
                inst = inst | 32'(f3 << 12) | 32'h03;
            end else if (kind <= 8) begin
                f3 = kind - 6;
                inst = inst | 32'(f3 << 12) | 32'h23;
            end else if (kind == 9) begin
                f3 = bad_f3[$urandom_range(0, 2)];
                inst = inst | 32'(f3 << 12) | 32'h03;
            end else begin
                f3 = $urandom_range(3, 7);
                inst = inst | 32'(f3 << 12) | 32'h23;
            end
            addr = $urandom;
            if (((inst >> 12) % 4) == 1) addr = addr & 32'hFFFF_FFFE;
            if (((inst >> 12) % 4) == 2) addr = addr & 32'hFFFF_FFFC;
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            run_op($sformatf("rnd%0d", i), inst, addr, $urandom, a, b,
                   $urandom, ($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/ysyx_24090012_lsu_resp.md
Name: ysyx_24090012_lsu_resp

Overview:
Responder end of the EXU→LSU memory handshake. Accepts the EXU request (mem_valid/mem_addr/mem_wdata plus the instruction word), decodes load/store width from the instruction and runs one access on a valid/ready data-memory bus. It byte-aligns write data/mask and extracts/extends load data, then returns a one-cycle mem_ready. Non-memory instructions also get mem_ready, because the EXU waits for it on every instruction.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before forced completion with error (1..65535)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_valid  in  1  EXU request, held high until mem_ready seen
mem_addr  in  32  effective address (rs1+imm)
mem_wdata  in  32  store data (rs2)
exu_to_lsu_inst  in  32  instruction word; opcode [6:0], funct3 [14:12]
mem_ready  out  1  one-cycle completion pulse to EXU
lsu_rdata  out  32  extended load result, held until next completion
lsu_inst  out  32  latched instruction, for WBU
lsu_err  out  1  valid with mem_ready: bus error, timeout or misalign
dmem_valid  out  1  bus request
dmem_ready  in  1  bus accepts request
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_wmask  out  4  byte strobes
dmem_rvalid  in  1  response (load data or store ack)
dmem_rdata  in  32  load word
dmem_err  in  1  qualified by dmem_rvalid

Behaviour:
- Reset (async, rst_n=0, any state incl. mid-access): state IDLE. All outputs 0. Timeout counter 0. An in-flight bus response after reset is dropped.
- Decode: opcode 0000011 = load, 0100011 = store, others = non-mem. Load funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store funct3 000 SB, 001 SH, 010 SW. Unlisted funct3 on load/store is treated as non-mem.
- States IDLE, REQ, WAIT, DONE.
- IDLE: mem_valid=1 latches addr/wdata/inst. Next state is REQ for mem ops, DONE for non-mem.
- REQ: dmem_valid=1, with we/addr/wdata/wmask stable. On dmem_ready go to WAIT. dmem_rvalid is ignored in REQ.
- WAIT: on dmem_rvalid go to DONE. Capture loads into lsu_rdata. Set lsu_err=dmem_err.
- DONE: mem_ready=1 for exactly one cycle, then IDLE. mem_valid is ignored in DONE, because the EXU still holds it high in that cycle.
- Latency (accept edge = cycle t):
  - non-mem: mem_ready in t+1.
  - mem with zero-wait bus: dmem_valid in t+1, rvalid in t+2, mem_ready in t+3.
- Timeout: counter runs in REQ and WAIT. Reaching TIMEOUT_CYCLES forces DONE with lsu_err=1 and lsu_rdata unchanged. A late rvalid is dropped.
- Store mask (o=addr[1:0]): SB 0001<<o, SH 0011<<o, SW 1111. The mask is truncated to 4 bits, so SH at o=3 gives 1000.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load: shift dmem_rdata right by 8*o. LB/LH sign-extend bit 7/15. LBU/LHU zero-extend. LW passes through.
- lsu_err is 0 on non-mem completions and on successful accesses.
- lsu_inst updates at accept.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, go straight to DONE. No dmem_valid is issued, and mem_ready carries lsu_err=1.
- Undefined: no check; truncated-mask behaviour above applies.

Test Plan:
1. Non-mem instruction 0x00500093, mem_valid at t → mem_ready=1 only at t+1, dmem_valid never high, lsu_err=0.
2. SB addr 0x80000003 wdata 0x000000AB, zero-wait bus → dmem_addr 0x80000000, wmask 1000, wdata 0xABABABAB, we=1, mem_ready at t+3.
3. LB addr 0x80000002, rdata 0x12F45678 → lsu_rdata 0xFFFFFFF4. LBU at the same address → 0x000000F4. LHU at 0x80000002 → 0x000012F4.
4. LW with dmem_ready delayed 3 cycles and rvalid 2 further cycles, dmem_err=1 → dmem_valid held 4 cycles with stable addr, mem_ready pulse with lsu_err=1.
5. TIMEOUT_CYCLES=8, dmem_ready held 0 → mem_ready after 8 cycles in REQ, lsu_err=1. A later rvalid is ignored and the next non-mem op completes normally.
6. rst_n pulsed low during WAIT → all outputs 0 immediately. With LSU_MISALIGN_CHECK_EN, LW at 0x80000002 → mem_ready at t+1, lsu_err=1, no dmem_valid.
